mem_arbiter: RTL and testbench

Two-port arbiter sharing one single-port synchronous data memory between the ARM core's data side and a secondary bus master, such as a display or DMA reader. It sits between the processor's MemWrite/ALUResult/WriteData/ReadData signals and the data RAM. Each access is sequenced through a small FSM, and a per-requester stall is raised so the core can hold its current instruction while the memory is busy.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_rr_pick2.sv | 25 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Define MEM_ARB_RR_EN for round-robin arbitration.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_PER
  } owner_t;

endpackage

// File: rtl/mem_arb_rr_pick2.sv
// Two-way request picker for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin, otherwise CPU priority.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   per_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t last,
`endif
  output owner_t win
);

`ifdef MEM_ARB_RR_EN
  // On a tie the master that was not served last wins.
  always_comb begin
    win = OWN_CPU;
    if (per_req && (!cpu_req || last == OWN_CPU))
      win = OWN_PER;
  end
`else
  assign win = (per_req && !cpu_req) ? OWN_PER : OWN_CPU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous data RAM between the core and a bus master.
// MEM_ARB_RR_EN selects round-robin, otherwise CPU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              per_req,
  input  logic              per_we,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_gnt,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_nx;
  owner_t     win, owner;
  logic       any_req, take;

  assign any_req = cpu_req | per_req;
  assign take    = (state == IDLE) && any_req;

`ifdef MEM_ARB_RR_EN
  owner_t last;

  rr_pick2 u_pick (
    .cpu_req (cpu_req),
    .per_req (per_req),
    .last    (last),
    .win     (win)
  );

  // Reset to PER so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    last <= OWN_PER;
    else if (take) last <= win;
  end
`else
  rr_pick2 u_pick (
    .cpu_req (cpu_req),
    .per_req (per_req),
    .win     (win)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // mem_we holds the captured direction throughout ACCESS.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = mem_we ? IDLE : RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_CPU;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      per_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      per_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      per_rdata  <= '0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      cpu_gnt    <= 1'b0;
      per_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      per_rvalid <= 1'b0;
      if (take) begin
        owner   <= win;
        mem_en  <= 1'b1;
        cpu_gnt <= (win == OWN_CPU);
        per_gnt <= (win == OWN_PER);
        if (win == OWN_CPU) begin
          mem_we    <= cpu_we;
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
        end else begin
          mem_we    <= per_we;
          mem_addr  <= per_addr;
          mem_wdata <= per_wdata;
        end
      end
      if (state == RESP) begin
        if (owner == OWN_CPU) begin
          cpu_rdata  <= mem_rdata;
          cpu_rvalid <= 1'b1;
        end else begin
          per_rdata  <= mem_rdata;
          per_rvalid <= 1'b1;
        end
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_rvalid & ~(cpu_gnt & mem_we);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases then random traffic
// against a transaction-level model (honours MEM_ARB_RR_EN).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        per_req, per_we, per_gnt, per_rvalid;
  logic [31:0] per_addr, per_wdata, per_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_gnt(per_gnt),
    .per_rvalid(per_rvalid), .per_rdata(per_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] ram [16];
  logic [31:0] shadow [16];

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[5:2]];
    if (mem_en && mem_we) ram[mem_addr[5:2]] <= mem_wdata;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)",
                  tag, got, exp, $time);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    per_req = 0; per_we = 0; per_addr = 0; per_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    nxt();
  endtask

  // transaction-level model state
  bit          t_act, t_own, t_we;
  int          t_start;
  logic [31:0] t_addr, t_wdata, t_rdata;
  bit          m_last_per;
  logic [31:0] e_crd, e_prd;
  bit          c_pend, p_pend, c_gprev, p_gprev;

  logic [8:0] cm, pm, cr, pr;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]    = (i == 1) ? 32'h12345678 : 32'hC0DE0000 + i;
      shadow[i] = ram[i];
    end

    reset_dut();
    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_gnt", {cpu_gnt, per_gnt}, 0);
    check("rst_rvalid", {cpu_rvalid, per_rvalid}, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_per_rdata", per_rdata, 0);

    // CPU write alone, then a read proving IDLE in cycle 2
    nxt();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40;
    cpu_wdata = 32'hDEADBEEF;
    shadow[0] = 32'hDEADBEEF;
    @(negedge clk) check("wr_stall_c0", cpu_stall, 1);
    nxt();
    @(negedge clk);
    check("wr_gnt", cpu_gnt, 1);
    check("wr_mem_en", mem_en, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_addr", mem_addr, 32'h40);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr_stall_c1", cpu_stall, 0);
    nxt();
    cpu_we = 0; cpu_addr = 32'h44;
    @(negedge clk);
    check("wr_c2_en", mem_en, 0);
    check("rd_stall_c0", cpu_stall, 1);
    nxt();
    @(negedge clk);
    check("rd_gnt", cpu_gnt, 1);
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_addr", mem_addr, 32'h44);
    check("rd_stall_c1", cpu_stall, 1);
    nxt();
    @(negedge clk);
    check("rd_rvalid_c2", cpu_rvalid, 0);
    check("rd_stall_c2", cpu_stall, 1);
    nxt();
    cpu_req = 0;
    @(negedge clk);
    check("rd_rvalid_c3", cpu_rvalid, 1);
    check("rd_rdata", cpu_rdata, 32'h12345678);
    check("rd_per_rvalid", per_rvalid, 0);
    check("rd_per_rdata", per_rdata, 0);

    // reset while the read sits in RESP
    nxt();
    cpu_req = 1; cpu_addr = 32'h48;
    nxt();
    nxt();
    cpu_req = 0;
    #2 reset = 1'b0;
    #1;
    check("mr_mem_en", mem_en, 0);
    check("mr_mem_addr", mem_addr, 0);
    check("mr_gnt", cpu_gnt, 0);
    check("mr_rvalid", cpu_rvalid, 0);
    check("mr_rdata", cpu_rdata, 0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      @(negedge clk) check("mr_no_rvalid", cpu_rvalid, 0);
    end
    nxt();
    cpu_req = 1; cpu_addr = 32'h48;
    nxt();
    nxt();
    nxt();
    cpu_req = 0;
    @(negedge clk);
    check("mr_rd_rvalid", cpu_rvalid, 1);
    check("mr_rd_rdata", cpu_rdata, shadow[2]);

    // both masters read continuously
    reset_dut();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4C;
    per_req = 1; per_we = 0; per_addr = 32'h50;
    cm = 0; pm = 0; cr = 0; pr = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      cm[c] = cpu_gnt; pm[c] = per_gnt;
      cr[c] = cpu_rvalid; pr[c] = per_rvalid;
      if (c == 3) begin
        check("ct_per_hold", per_rdata, 0);
        check("ct_cpu_rdata", cpu_rdata, shadow[3]);
      end
      nxt();
    end
`ifdef MEM_ARB_RR_EN
    check("ct_cpu_gnts", cm, 9'h082);
    check("ct_per_gnts", pm, 9'h010);
    check("ct_cpu_rv", cr, 9'h008);
    check("ct_per_rv", pr, 9'h040);
`else
    check("ct_cpu_gnts", cm, 9'h092);
    check("ct_per_gnts", pm, 9'h000);
    check("ct_cpu_rv", cr, 9'h048);
    check("ct_per_rv", pr, 9'h000);
`endif
    cpu_req = 0;
    @(negedge clk) check("ct_per_gnt_c9", per_gnt, 0);
    nxt();
    @(negedge clk);
    check("ct_per_gnt_c10", per_gnt, 1);
    check("ct_per_addr", mem_addr, 32'h50);
    nxt();
    per_req = 0;
    nxt();
    @(negedge clk);
    check("ct_per_rvalid", per_rvalid, 1);
    check("ct_per_rdata", per_rdata, shadow[4]);

    // peripheral request raised while a CPU write is in ACCESS
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h54;
    cpu_wdata = 32'h5A5A0001;
    shadow[5] = 32'h5A5A0001;
    nxt();
    per_req = 1; per_we = 0; per_addr = 32'h58;
    @(negedge clk) check("la_cpu_gnt", cpu_gnt, 1);
    nxt();
    cpu_req = 0;
    @(negedge clk) check("la_per_gnt_idle", per_gnt, 0);
    nxt();
    @(negedge clk);
    check("la_per_gnt", per_gnt, 1);
    check("la_per_addr", mem_addr, 32'h58);
    nxt();
    per_req = 0;
    nxt();
    nxt();
    @(negedge clk) check("la_per_rdata", per_rdata, shadow[6]);

    // random traffic against the transaction model
    reset_dut();
    t_act = 0; t_start = 0; t_own = 0; t_we = 0;
    t_addr = 0; t_wdata = 0; t_rdata = 0;
    m_last_per = 1; e_crd = 0; e_prd = 0;
    c_pend = 0; p_pend = 0; c_gprev = 0; p_gprev = 0;
    for (int c = 0; c < 600; c++) begin
      bit eg_c, eg_p, ev_c, ev_p, e_en, e_we, idle, own;
      logic [31:0] e_a, e_d;
      e_en = t_act && (c == t_start + 1);
      eg_c = e_en && !t_own;
      eg_p = e_en && t_own;
      e_we = t_we; e_a = t_addr; e_d = t_wdata;
      ev_c = t_act && !t_we && (c == t_start + 3) && !t_own;
      ev_p = t_act && !t_we && (c == t_start + 3) && t_own;
      if (ev_c) e_crd = t_rdata;
      if (ev_p) e_prd = t_rdata;
      idle = !t_act || (c >= t_start + (t_we ? 2 : 3));

      if (c_gprev) begin
        cpu_req = 0; c_pend = 0;
      end else if (!c_pend && $urandom_range(0, 2) == 0) begin
        c_pend = 1; cpu_req = 1; cpu_we = 1'($urandom);
        cpu_addr = $urandom & 32'hFFFF_FFFC;
        cpu_wdata = $urandom;
      end
      if (p_gprev) begin
        per_req = 0; p_pend = 0;
      end else if (!p_pend && $urandom_range(0, 2) == 0) begin
        p_pend = 1; per_req = 1; per_we = 1'($urandom);
        per_addr = $urandom & 32'hFFFF_FFFC;
        per_wdata = $urandom;
      end
      c_gprev = eg_c; p_gprev = eg_p;

      if (idle && (cpu_req || per_req)) begin
`ifdef MEM_ARB_RR_EN
        own = (cpu_req && per_req) ? !m_last_per : per_req;
`else
        own = per_req && !cpu_req;
`endif
        m_last_per = own;
        t_act = 1; t_start = c; t_own = own;
        t_we    = own ? per_we : cpu_we;
        t_addr  = own ? per_addr : cpu_addr;
        t_wdata = own ? per_wdata : cpu_wdata;
        if (t_we) shadow[t_addr[5:2]] = t_wdata;
        else t_rdata = shadow[t_addr[5:2]];
      end

      @(negedge clk);
      check("rn_cpu_gnt", cpu_gnt, eg_c);
      check("rn_per_gnt", per_gnt, eg_p);
      check("rn_mem_en", mem_en, e_en);
      if (e_en) begin
        check("rn_mem_we", mem_we, e_we);
        check("rn_mem_addr", mem_addr, e_a);
        if (e_we) check("rn_mem_wdata", mem_wdata, e_d);
      end
      check("rn_cpu_rvalid", cpu_rvalid, ev_c);
      check("rn_per_rvalid", per_rvalid, ev_p);
      check("rn_cpu_rdata", cpu_rdata, e_crd);
      check("rn_per_rdata", per_rdata, e_prd);
      check("rn_cpu_stall", cpu_stall,
            cpu_req && !ev_c && !(eg_c && e_we));
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
